exibidor_paridade_multiplexado: RTL and testbench

Parametrised successor to the single-character parity check and 7-segment display path. It accepts parity-protected character words over a valid/ready handshake and checks each word for even or odd parity. Accepted words shift into a DIGITS-deep display buffer, which is shown on a time-multiplexed multi-digit 7-segment display. The block also keeps a saturating parity-error counter. It sits between the character source and the board display pins.

---
 rtl/exibidor_paridade_multiplexado_pkg.sv | 25 ++
 rtl/exibidor_paridade_multiplexado_mapeamento_glifo.sv | 36 +++
 rtl/exibidor_paridade_multiplexado.sv | 125 ++++++++++++
 tb/tb_exibidor_paridade_multiplexado.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exibidor_paridade_multiplexado_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exibidor_paridade_multiplexado_pkg                                 |
// | Segment glyph constants and display-buffer entry layout.           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package exibidor_paridade_multiplexado_pkg;

  localparam logic [6:0] GLIFO_BLANK    = 7'h00;
  localparam logic [6:0] GLIFO_ERRO     = 7'h49;
  localparam logic [6:0] GLIFO_INVALIDO = 7'h08;

  // Entry 15 sits in the most significant slot, entry 0 in the least.
  localparam logic [15:0][6:0] TABELA_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Entry layout {used, err, code}: flag bit positions are offsets above DATA_W.
  localparam int ENT_FLAGS_W  = 2;
  localparam int ENT_USED_OFS = 1;
  localparam int ENT_ERR_OFS  = 0;

endpackage
`default_nettype wire

// File: rtl/exibidor_paridade_multiplexado_mapeamento_glifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mapeamento_glifo                                                   |
// | Combinational entry-to-7-segment glyph mapping.                    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mapeamento_glifo
  import exibidor_paridade_multiplexado_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic              used,
  input  logic              err,
  input  logic [DATA_W-1:0] code,
  output logic [6:0]        seg
);

  // Zero-extend so the hex-range test also works for DATA_W < 4.
  logic [DATA_W+3:0] w_code_ext;
  assign w_code_ext = {4'b0000, code};

  always_comb begin
    seg = GLIFO_BLANK;
    if (!used) begin
      seg = GLIFO_BLANK;
    end else if (err) begin
      seg = GLIFO_ERRO;
    end else if (~|w_code_ext[DATA_W+3:4]) begin
      seg = TABELA_HEX[w_code_ext[3:0]];
    end else begin
      seg = GLIFO_INVALIDO;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exibidor_paridade_multiplexado.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exibidor_paridade_multiplexado                                     |
// | Parity-checked character buffer on a multiplexed 7-segment display.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module exibidor_paridade_multiplexado
  import exibidor_paridade_multiplexado_pkg::*;
#(
  parameter int DATA_W     = 5,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W:0]      in_data,
  input  logic                 hold,
  input  logic                 clear,
  output logic [6:0]           seg,
  output logic [DIGITS-1:0]    an,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_flag
);

  localparam int ENT_W    = DATA_W + ENT_FLAGS_W;
  localparam int USED_BIT = DATA_W + ENT_USED_OFS;
  localparam int ERR_BIT  = DATA_W + ENT_ERR_OFS;
  localparam int PRESC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [ENT_W-1:0]     buf_q [DIGITS];
  logic [ENT_W-1:0]     buf_d [DIGITS];
  logic                 in_ready_q;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_flag_q, err_flag_d;

  logic w_xfer;
  logic w_err;
  logic w_wrap;

  // clear takes priority: a handshake in the same cycle is discarded.
  assign w_xfer = in_valid & in_ready_q & ~clear;
  assign w_err  = (^in_data) != (ODD_PARITY != 0);

  always_comb begin
    for (int i = 0; i < DIGITS; i++) buf_d[i] = buf_q[i];
    if (clear) begin
      for (int i = 0; i < DIGITS; i++) buf_d[i] = '0;
    end else if (w_xfer) begin
      for (int i = 1; i < DIGITS; i++) buf_d[i] = buf_q[i-1];
      buf_d[0] = {1'b1, w_err, in_data[DATA_W:1]};
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = w_xfer & w_err;
    if (clear) begin
      err_cnt_d = '0;
    end else if (w_xfer && w_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign w_wrap  = (presc_q == PRESC_W'(SCAN_DIV - 1));
  assign presc_d = w_wrap ? '0 : presc_q + PRESC_W'(1);

  generate
    if (DIGITS == 1) begin : g_idx_single
      assign idx_d = '0;
    end else begin : g_idx_multi
      assign idx_d = !w_wrap ? idx_q :
                     (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  endgenerate

  mapeamento_glifo #(
    .DATA_W (DATA_W)
  ) u_glifo (
    .used (buf_q[idx_q][USED_BIT]),
    .err  (buf_q[idx_q][ERR_BIT]),
    .code (buf_q[idx_q][DATA_W-1:0]),
    .seg  (seg_d)
  );

  assign an_d = DIGITS'(1) << idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= '0;
      in_ready_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= GLIFO_BLANK;
      an_q       <= DIGITS'(1);
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= buf_d[i];
      in_ready_q <= ~hold & ~clear;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign err_count = err_cnt_q;
  assign err_flag  = err_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_exibidor_paridade_multiplexado.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exibidor_paridade_multiplexado                                  |
// | Directed self-checking bench, DIGITS=4, SCAN_DIV=2, ERR_CNT_W=2.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_exibidor_paridade_multiplexado;

  localparam int DATA_W    = 5;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 2;
  localparam int ERR_CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_W:0]      in_data = '0;
  logic                 hold = 1'b0;
  logic                 clear = 1'b0;
  logic [6:0]           seg;
  logic [DIGITS-1:0]    an;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_flag;

  int errors = 0;
  int checks = 0;

  exibidor_paridade_multiplexado #(
    .DATA_W     (DATA_W),
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ODD_PARITY (0),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .hold      (hold),
    .clear     (clear),
    .seg       (seg),
    .an        (an),
    .err_count (err_count),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one word from a falling edge and hold it until it is accepted.
  task automatic send(input logic [DATA_W:0] w, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for digit d to be enabled and capture its segments.
  task automatic read_digit(input int d, output logic [6:0] s, output bit ok);
    logic [DIGITS-1:0] want;
    want = DIGITS'(1) << d;
    ok = 1'b0;
    s  = 'x;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an === want) begin
        ok = 1'b1;
        s  = seg;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an [9];
    exp_an = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
               4'b0100, 4'b1000, 4'b1000, 4'b0001};
    repeat (2) @(negedge clk);
    checks++; if (an !== 4'b0001) begin errors++; $display("FAIL reset_an got=%b exp=0001", an); end
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg got=%h exp=00", seg); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", err_count); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", err_flag); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got=%b exp=1", in_ready); end
      end
      checks++; if (an !== exp_an[k]) begin errors++; $display("FAIL scan_an[%0d] got=%b exp=%b", k, an, exp_an[k]); end
      checks++; if (seg !== 7'h00) begin errors++; $display("FAIL scan_seg[%0d] got=%h exp=00", k, seg); end
    end
  endtask

  task automatic test_good_word;
    bit ok;
    logic [6:0] s;
    send(6'b000110, ok);
    checks++; if (!ok) begin errors++; $display("FAIL good_send timeout got=0 exp=1"); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL good_flag got=%b exp=0", err_flag); end
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 7'h4F) begin errors++; $display("FAIL good_seg got=%h ok=%0d exp=4f", s, ok); end
  endtask

  task automatic test_parity_error;
    bit ok;
    logic [6:0] s;
    send(6'b000010, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bad_send timeout got=0 exp=1"); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL bad_flag_hi got=%b exp=1", err_flag); end
    checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL bad_cnt got=%0d exp=1", err_count); end
    @(negedge clk);
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL bad_flag_lo got=%b exp=0", err_flag); end
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 7'h49) begin errors++; $display("FAIL bad_seg got=%h ok=%0d exp=49", s, ok); end
    send(6'b100100, ok);
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 7'h08) begin errors++; $display("FAIL invalid_seg got=%h ok=%0d exp=08", s, ok); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [6:0] s;
    logic [5:0] words [5];
    logic [6:0] exp_seg [4];
    words   = '{6'b000011, 6'b000101, 6'b000110, 6'b001001, 6'b001010};
    exp_seg = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
    for (int i = 0; i < 5; i++) send(words[i], ok);
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++; if (!ok || s !== exp_seg[d]) begin errors++; $display("FAIL shift_seg[%0d] got=%h ok=%0d exp=%h", d, s, ok, exp_seg[d]); end
    end
  endtask

  task automatic test_saturate_and_clear;
    bit ok;
    logic [6:0] s;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL clear_cnt got=%0d exp=0", err_count); end
    for (int i = 0; i < 5; i++) begin
      send(6'b000010, ok);
      checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL sat_flag[%0d] got=%b exp=1", i, err_flag); end
      checks++; if (err_count !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, err_count, exp_cnt[i]); end
    end
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pre_clear_ready got=%b exp=1", in_ready); end
    clear = 1'b1; in_valid = 1'b1; in_data = 6'b000010;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL clear_wins_cnt got=%0d exp=0", err_count); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL clear_wins_flag got=%b exp=0", err_flag); end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++; if (!ok || s !== 7'h00) begin errors++; $display("FAIL clear_seg[%0d] got=%h ok=%0d exp=00", d, s, ok); end
    end
  endtask

  task automatic test_hold_and_async_reset;
    bit ok;
    logic [6:0] s;
    send(6'b000110, ok);
    send(6'b000010, ok);
    @(negedge clk); hold = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b exp=0", in_ready); end
    in_valid = 1'b1; in_data = 6'b000010;
    repeat (4) @(negedge clk);
    in_valid = 1'b0; hold = 1'b0;
    checks++; if (err_count !== 2'd1) begin errors++; $display("FAIL hold_cnt got=%0d exp=1", err_count); end
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 7'h49) begin errors++; $display("FAIL hold_seg0 got=%h ok=%0d exp=49", s, ok); end
    read_digit(1, s, ok);
    checks++; if (!ok || s !== 7'h4F) begin errors++; $display("FAIL hold_seg1 got=%h ok=%0d exp=4f", s, ok); end
    read_digit(2, s, ok);
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 4'b0001) begin errors++; $display("FAIL async_an got=%b exp=0001", an); end
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL async_seg got=%h exp=00", seg); end
    checks++; if (err_count !== 2'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", err_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_ready got=%b exp=0", in_ready); end
    @(negedge clk); rst = 1'b0;
    read_digit(1, s, ok);
    checks++; if (!ok || s !== 7'h00) begin errors++; $display("FAIL post_reset_seg1 got=%h ok=%0d exp=00", s, ok); end
  endtask

  initial begin
    test_reset();
    test_good_word();
    test_parity_error();
    test_back_to_back();
    test_saturate_and_clear();
    test_hold_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
